// File: rtl/btb_file.sv
// Storage array for a 2-way, 8-set branch target buffer.
// Serves an IF lookup port with same-cycle write forwarding and an EX update port, and
// sequences an invalidate-all flush that clears one set per cycle.
module btb_file #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned INDEX_W  = 3,
  parameter int unsigned SET_W    = 128
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [INDEX_W-1:0]  i_read_index,
  output logic [SET_W-1:0]    o_read_set,
  input  logic [INDEX_W-1:0]  i_update_index,
  output logic [SET_W-1:0]    o_update_set,
  output logic [NUM_SETS-1:0] o_lru,
  input  logic                i_write_en,
  input  logic [SET_W-1:0]    i_write_set,
  input  logic                i_next_lru_write,
  input  logic                i_flush,
  output logic                o_busy
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [INDEX_W-1:0] r_fcnt;
  logic [INDEX_W-1:0] w_fcnt_next;

  logic [SET_W-1:0]    r_sets [NUM_SETS];
  logic [NUM_SETS-1:0] r_lru;

  logic w_busy;
  logic w_do_write;
  logic w_fwd;

  assign w_busy     = (r_state == StFlush);
  // A flush request in the same idle cycle takes priority over the write.
  assign w_do_write = !w_busy && i_write_en && !i_flush;
  assign w_fwd      = !w_busy && i_write_en && (i_read_index == i_update_index);

  // FSM state and flush counter registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_next;
      r_fcnt  <= w_fcnt_next;
    end
  end

  // Next-state logic: a flush walks every set once; a new request restarts the walk at set 0.
  always_comb begin
    w_state_next = r_state;
    w_fcnt_next  = r_fcnt;
    unique case (r_state)
      StIdle: begin
        if (i_flush) begin
          w_state_next = StFlush;
          w_fcnt_next  = '0;
        end
      end
      StFlush: begin
        if (i_flush) begin
          w_fcnt_next = '0;
        end else begin
          w_fcnt_next = r_fcnt + 1'b1;
          if (r_fcnt == INDEX_W'(NUM_SETS - 1)) begin
            w_state_next = StIdle;
          end
        end
      end
      default: begin
        w_state_next = StIdle;
        w_fcnt_next  = '0;
      end
    endcase
  end

  // Set array and LRU storage: commit writes when idle, clear valid bits and LRU while flushing.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_SETS; i++) begin
        r_sets[i] <= '0;
      end
      r_lru <= '0;
    end else if (w_do_write) begin
      r_sets[i_update_index] <= i_write_set;
      r_lru[i_update_index]  <= i_next_lru_write;
    end else if (w_busy) begin
      // Only the two valid bits go; tag/target/state are left as they were.
      r_sets[r_fcnt][SET_W-1]   <= 1'b0;
      r_sets[r_fcnt][SET_W/2-1] <= 1'b0;
      r_lru[r_fcnt]             <= 1'b0;
    end
  end

  // Combinational read ports; the update port is never forwarded to avoid a loop through the merge.
  always_comb begin
    o_read_set   = '0;
    o_update_set = '0;
    if (!w_busy) begin
      o_update_set = r_sets[i_update_index];
      o_read_set   = w_fwd ? i_write_set : r_sets[i_read_index];
    end
  end

  assign o_lru  = r_lru;
  assign o_busy = w_busy;

endmodule
